// File: rtl/map_lfsr_scan.sv
// Start/done sequencer: loads an operand, counts up to all-ones while stepping an XNOR LFSR,
// then captures the LFSR into dp. Optional continuous rerun, abort input and busy flag.
module map_lfsr_scan #(
  parameter int              DW   = 9,
  parameter int              SRW  = 8,
  parameter logic [SRW-1:0]  TAPS = 8'hB8,
  parameter logic [SRW-1:0]  SEED = '0,
  parameter bit              MODE = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [DW-1:0] n_in,
  output logic [DW-2:0] counter,
  output logic [SRW-1:0] sr,
  output logic [DW-1:0] dp,
  output logic          done,
  output logic          busy
);
  localparam int CW = DW - 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

  state_t         state_reg, state_next;
  logic           startbuf_reg;
  logic [CW-1:0]  counter_reg, counter_next;
  logic [SRW-1:0] sr_reg, sr_next;
  logic [DW-1:0]  dp_reg, dp_next;
  logic           done_reg, done_next;
  logic           busy_reg, busy_next;
  logic           trigger;
  logic           fb;
  logic [SRW-1:0] tapped;

  for (genvar gi = 0; gi < SRW; gi++) begin : g_tap
    assign tapped[gi] = sr_reg[gi] & TAPS[gi];
  end

  // XNOR feedback keeps the all-zero seed from being a lock-up state
  assign fb      = ~^tapped;
  assign trigger = start & ~startbuf_reg;

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    sr_next      = sr_reg;
    dp_next      = dp_reg;
    done_next    = done_reg;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next = LOAD;
          done_next  = 1'b0;
        end
      end
      LOAD: begin
        done_next = 1'b0;
        if (stop) begin
          state_next = IDLE;
        end else begin
          counter_next = n_in[DW-1:1];
          dp_next      = n_in;
          sr_next      = SEED;
          state_next   = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (&counter_reg) begin
          state_next = CAPTURE;
        end else begin
          counter_next = counter_reg + CW'(1);
          sr_next      = {sr_reg[SRW-2:0], fb};
        end
      end
      CAPTURE: begin
        dp_next            = '0;
        dp_next[SRW-1:0]   = sr_reg;
        done_next          = 1'b1;
        state_next         = MODE ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    // startbuf tracks start even in reset, so a start held high across reset release is not an edge
    startbuf_reg <= start;
    if (!reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      sr_reg      <= SEED;
      dp_reg      <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      sr_reg      <= sr_next;
      dp_reg      <= dp_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  assign counter = counter_reg;
  assign sr      = sr_reg;
  assign dp      = dp_reg;
  assign done    = done_reg;
  assign busy    = busy_reg;
endmodule

// File: tb/tb_map_lfsr_scan.sv
// Bench for map_lfsr_scan: single-shot instance exercised with directed and random operands
// against an arithmetic LFSR model, plus a continuous-mode instance.
module tb_map_lfsr_scan;
  logic       clock = 1'b0;
  logic       reset, start, stop;
  logic [8:0] n_in;
  logic [7:0] counter;
  logic [7:0] sr;
  logic [8:0] dp;
  logic       done, busy;

  logic       reset1, start1, stop1;
  logic [8:0] n1;
  logic [7:0] counter1;
  logic [7:0] sr1;
  logic [8:0] dp1;
  logic       done1, busy1;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  map_lfsr_scan #(.DW(9), .SRW(8), .TAPS(8'hB8), .SEED(8'h00), .MODE(1'b0)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .n_in(n_in),
    .counter(counter), .sr(sr), .dp(dp), .done(done), .busy(busy)
  );

  map_lfsr_scan #(.DW(9), .SRW(8), .TAPS(8'hB8), .SEED(8'h00), .MODE(1'b1)) dut_cont (
    .clock(clock), .reset(reset1), .start(start1), .stop(stop1), .n_in(n1),
    .counter(counter1), .sr(sr1), .dp(dp1), .done(done1), .busy(busy1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: shift an XNOR LFSR step by step, feedback = even parity of tapped bits
  function automatic logic [7:0] lfsr_ref(input int steps);
    logic [7:0] s;
    logic [7:0] taps;
    int ones;
    s = 8'h00;
    taps = 8'hB8;
    for (int k = 0; k < steps; k++) begin
      ones = 0;
      for (int b = 0; b < 8; b++) if (s[b] && taps[b]) ones++;
      s = {s[6:0], ((ones % 2) == 0)};
    end
    return s;
  endfunction

  // Pulse start, then count cycles after the trigger edge until done (bounded)
  task automatic pulse_and_wait(input logic [8:0] n, output int lat);
    n_in = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [8:0] n);
    int lat, shifts;
    logic [7:0] exp_sr;
    shifts = 255 - int'(n[8:1]);
    exp_sr = lfsr_ref(shifts);
    pulse_and_wait(n, lat);
    check({tag, "_latency"}, 32'(lat), 32'(3 + shifts));
    check({tag, "_done"},    32'(done), 32'd1);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_counter"}, 32'(counter), 32'hFF);
    check({tag, "_sr"},      32'(sr), 32'(exp_sr));
    check({tag, "_dp"},      32'(dp), 32'(exp_sr));
    $display("run %s n_in=%03h shifts=%0d latency=%0d dp=%03h", tag, n, shifts, lat, dp);
  endtask

  initial begin
    int lat;
    logic [8:0] rn;

    reset = 1'b0; start = 1'b1; stop = 1'b0; n_in = 9'h0;
    reset1 = 1'b0; start1 = 1'b0; stop1 = 1'b0; n1 = 9'h1FE;

    // 1. reset with start high, release without an edge
    tick(); tick();
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_counter", 32'(counter), 32'd0);
    check("rst_sr", 32'(sr), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    reset = 1'b1;
    tick();
    check("level_start_busy0", 32'(busy), 32'd0);
    tick();
    check("level_start_busy1", 32'(busy), 32'd0);
    start = 1'b0;
    tick();
    $display("reset sequence done busy=%0d", busy);

    // 2-4. directed boundary operands
    run_and_check("zero_shift", 9'h1FE);
    check("zero_shift_dp_const", 32'(dp), 32'h000);
    run_and_check("one_shift", 9'h1FC);
    check("one_shift_sr_const", 32'(sr), 32'h01);
    check("one_shift_dp_const", 32'(dp), 32'h001);
    tick(); tick();
    check("done_holds", 32'(done), 32'd1);
    run_and_check("full_run", 9'h000);

    // random operands
    for (int i = 0; i < 5; i++) begin
      rn = 9'($urandom_range(0, 511));
      run_and_check("random", rn);
    end

    // retrigger while busy is ignored, not queued
    n_in = 9'h1F0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    lat = 3;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    check("retrigger_latency", 32'(lat), 32'd10);
    check("retrigger_sr", 32'(sr), 32'(lfsr_ref(7)));
    tick(); tick(); tick();
    check("retrigger_no_queue_busy", 32'(busy), 32'd0);
    check("retrigger_no_queue_done", 32'(done), 32'd1);
    $display("retrigger test latency=%0d busy=%0d", lat, busy);

    // 5a. abort on the 10th RUN cycle
    n_in = 9'h000;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    repeat (9) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_counter", 32'(counter), 32'd9);
    check("abort_sr", 32'(sr), 32'(lfsr_ref(9)));
    tick(); tick();
    check("abort_counter_hold", 32'(counter), 32'd9);
    check("abort_still_idle", 32'(busy), 32'd0);
    $display("abort counter=%0d sr=%02h", counter, sr);

    // 5b. reset mid-run
    n_in = 9'h100;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_counter", 32'(counter), 32'd0);
    check("midrun_rst_sr", 32'(sr), 32'd0);
    check("midrun_rst_dp", 32'(dp), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    tick();
    check("midrun_after_rst_busy", 32'(busy), 32'd0);
    $display("mid-run reset busy=%0d counter=%0d", busy, counter);

    // 6. continuous mode: done pulses every third cycle, extra start edge changes nothing
    reset1 = 1'b1;
    tick();
    start1 = 1'b1; tick(); start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
    check("cont_first_latency", 32'(lat), 32'd3);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) start1 = 1'b1;
      if (k == 5) start1 = 1'b0;
      check("cont_done_pattern", 32'(done1), 32'((k % 3) == 0));
      check("cont_busy", 32'(busy1), 32'd1);
      if ((k % 3) == 0) check("cont_dp", 32'(dp1), 32'h000);
      $display("cont cycle %0d done=%0d busy=%0d dp=%03h", k, done1, busy1, dp1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
